// File: rtl/bayer_demosaic_2x2.sv
// rtl/bayer_demosaic_2x2.sv - Bayer 2x2 window to half-resolution RGB / grayscale converter
module bayer_demosaic_2x2 #(
  parameter int DATA_W = 12,
  parameter int X_W    = 11,
  parameter int LINE_W = 640
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [X_W-1:0]    iX_Cont,
  input  logic [X_W-1:0]    iY_Cont,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [1:0]        iPATTERN,
  input  logic              iMODE,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic [X_W-1:0]    oX,
  output logic [X_W-1:0]    oY,
  output logic              oDVAL
);

  localparam int          AW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [31:0] LINE_LIM = 32'(LINE_W);

  logic              accept;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] line_mem [LINE_W];
  logic [DATA_W-1:0] rd_q;

  logic              s1_vld_q, s1_win_q, s1_mode_q;
  logic [DATA_W-1:0] s1_pix_q;
  logic [X_W-1:0]    s1_x_q, s1_y_q;
  logic [1:0]        s1_pat_q;
  logic [DATA_W-1:0] col_cur_q, col_prev_q;

  logic              s2_vld_q;
  logic [DATA_W-1:0] s2_r_q, s2_g_q, s2_b_q;
  logic [X_W-1:0]    s2_x_q, s2_y_q;

  logic [DATA_W-1:0] red_d, green_d, blue_d, g1, g2, gray;
  logic [DATA_W-1:0] p00, p01, p10, p11;

  logic [DATA_W-1:0] red_q, green_q, blue_q;
  logic [X_W-1:0]    ox_q, oy_q;
  logic              dval_q;

  assign accept = iDVAL && ({{(32-X_W){1'b0}}, iX_Cont} < LINE_LIM);
  assign addr   = iX_Cont[AW-1:0];

  // Line buffer is deliberately not reset; read-before-write returns the previous row.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      rd_q           <= line_mem[addr];
      line_mem[addr] <= iDATA;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_vld_q  <= 1'b0;
      s1_win_q  <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_pix_q  <= '0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_pat_q  <= '0;
    end else begin
      s1_vld_q <= accept;
      s1_win_q <= accept && iX_Cont[0] && iY_Cont[0];
      if (accept) begin
        s1_pix_q  <= iDATA;
        s1_x_q    <= iX_Cont >> 1;
        s1_y_q    <= iY_Cont >> 1;
        s1_pat_q  <= iPATTERN;
        s1_mode_q <= iMODE;
      end
    end
  end

  // Window: top row from the line buffer, left column from the column registers.
  assign p00 = col_prev_q;
  assign p01 = rd_q;
  assign p10 = col_cur_q;
  assign p11 = s1_pix_q;

  always_comb begin
    red_d = p00;
    blue_d = p11;
    g1 = p01;
    g2 = p10;
    case (s1_pat_q)
      2'd1: begin red_d = p01; blue_d = p10; g1 = p00; g2 = p11; end
      2'd2: begin red_d = p10; blue_d = p01; g1 = p00; g2 = p11; end
      2'd3: begin red_d = p11; blue_d = p00; g1 = p01; g2 = p10; end
      default: ;
    endcase
    green_d = DATA_W'(({1'b0, g1} + {1'b0, g2}) >> 1);
    gray    = DATA_W'(({2'b0, p00} + {2'b0, p01} + {2'b0, p10} + {2'b0, p11}) >> 2);
    if (s1_mode_q) begin
      red_d   = gray;
      green_d = gray;
      blue_d  = gray;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_cur_q  <= '0;
      col_prev_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_r_q     <= '0;
      s2_g_q     <= '0;
      s2_b_q     <= '0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
    end else begin
      if (s1_vld_q) begin
        col_cur_q  <= s1_pix_q;
        col_prev_q <= rd_q;
      end
      s2_vld_q <= s1_win_q;
      if (s1_win_q) begin
        s2_r_q <= red_d;
        s2_g_q <= green_d;
        s2_b_q <= blue_d;
        s2_x_q <= s1_x_q;
        s2_y_q <= s1_y_q;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      dval_q  <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      dval_q <= s2_vld_q;
      if (s2_vld_q) begin
        red_q   <= s2_r_q;
        green_q <= s2_g_q;
        blue_q  <= s2_b_q;
        ox_q    <= s2_x_q;
        oy_q    <= s2_y_q;
      end
    end
  end

  assign oRed   = red_q;
  assign oGreen = green_q;
  assign oBlue  = blue_q;
  assign oX     = ox_q;
  assign oY     = oy_q;
  assign oDVAL  = dval_q;

endmodule

// File: tb/tb_bayer_demosaic_2x2.sv
// tb/tb_bayer_demosaic_2x2.sv - scoreboard bench for bayer_demosaic_2x2 at LINE_W=8
module tb_bayer_demosaic_2x2;

  localparam int DW = 12;
  localparam int XW = 11;
  localparam int LW = 8;
  localparam int ROWS = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [XW-1:0] x_in, y_in;
  logic [DW-1:0] d_in;
  logic          dval_in;
  logic [1:0]    pat_in;
  logic          mode_in;
  logic [DW-1:0] o_r, o_g, o_b;
  logic [XW-1:0] o_x, o_y;
  logic          o_dval;

  always #5 clk = ~clk;

  bayer_demosaic_2x2 #(.DATA_W(DW), .X_W(XW), .LINE_W(LW)) dut (
    .iCLK(clk), .iRST(rst), .iX_Cont(x_in), .iY_Cont(y_in), .iDATA(d_in),
    .iDVAL(dval_in), .iPATTERN(pat_in), .iMODE(mode_in),
    .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .oX(o_x), .oY(o_y), .oDVAL(o_dval)
  );

  typedef struct {
    int r; int g; int b; int x; int y; int due;
  } exp_t;

  exp_t sb_q[$];
  exp_t log_q[$];
  exp_t mon_e, mon_a;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   img [ROWS][LW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Red sits at quad position == pattern code, blue diagonally opposite; the rest is green.
  function automatic exp_t model(input int p00, input int p01, input int p10, input int p11,
                                 input int pat, input int md, input int ox, input int oy,
                                 input int due);
    exp_t e;
    int p [4];
    int total;
    p[0] = p00; p[1] = p01; p[2] = p10; p[3] = p11;
    total = p00 + p01 + p10 + p11;
    if (md != 0) begin
      e.r = total / 4; e.g = total / 4; e.b = total / 4;
    end else begin
      e.r = p[pat];
      e.b = p[3 - pat];
      e.g = (total - e.r - e.b) / 2;
    end
    e.x = ox; e.y = oy; e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (o_dval) begin
      mon_a.r = int'(o_r); mon_a.g = int'(o_g); mon_a.b = int'(o_b);
      mon_a.x = int'(o_x); mon_a.y = int'(o_y); mon_a.due = cyc;
      log_q.push_back(mon_a);
      if (sb_q.size() == 0) begin
        check("spurious_dval", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("latency", cyc, mon_e.due);
        check("red", mon_a.r, mon_e.r);
        check("green", mon_a.g, mon_e.g);
        check("blue", mon_a.b, mon_e.b);
        check("out_x", mon_a.x, mon_e.x);
        check("out_y", mon_a.y, mon_e.y);
      end
    end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      check("missing_dval", 0, 1);
      sb_q.delete(0);
    end
  end

  task automatic drive_pix(input int x, input int y, input int d, input int pat, input int md);
    @(posedge clk);
    #1;
    x_in = XW'(x); y_in = XW'(y); d_in = DW'(d);
    pat_in = 2'(pat); mode_in = md[0]; dval_in = 1'b1;
    if (x < LW) begin
      img[y][x] = d;
      if (x % 2 == 1 && y % 2 == 1)
        sb_q.push_back(model(img[y-1][x-1], img[y-1][x], img[y][x-1], d,
                             pat, md, x / 2, y / 2, cyc + 3));
    end
  endtask

  task automatic bubble();
    @(posedge clk);
    #1;
    dval_in = 1'b0;
    d_in = DW'($urandom);
    x_in = XW'($urandom_range(0, 9));
    y_in = XW'($urandom_range(0, 5));
  endtask

  function automatic int gen(input int kind, input int x, input int y);
    case (kind)
      0: return 8 * y + x + 1;
      1: return 'hFFF;
      2: begin
        if (x % 2 == 1 && y % 2 == 0) return 'hFFF;
        if (x % 2 == 0 && y % 2 == 1) return 'h001;
        return int'($urandom_range(0, 'hFFF));
      end
      default: return int'($urandom_range(0, 'hFFF));
    endcase
  endfunction

  // bub: 0 none, 1 after every pixel, 2 random
  task automatic stream_frame(input int kind, input int pat, input int md, input bit rnd_cfg,
                              input int bub, input int xmax);
    int p, m;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < xmax; x++) begin
        p = rnd_cfg ? int'($urandom_range(0, 3)) : pat;
        m = rnd_cfg ? int'($urandom_range(0, 1)) : md;
        drive_pix(x, y, gen(kind, x, y), p, m);
        if (bub == 1 || (bub == 2 && $urandom_range(0, 3) == 0)) bubble();
      end
    end
  endtask

  task automatic drain();
    bubble();
    repeat (8) @(posedge clk);
    #1;
    check("drain_empty", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic check_first(input string tag, input int r, input int g, input int b);
    check({tag, "_count"}, log_q.size(), 12);
    check({tag, "_r"}, log_q[0].r, r);
    check({tag, "_g"}, log_q[0].g, g);
    check({tag, "_b"}, log_q[0].b, b);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dval"}, int'(o_dval), 0);
    check({tag, "_r"}, int'(o_r), 0);
    check({tag, "_g"}, int'(o_g), 0);
    check({tag, "_b"}, int'(o_b), 0);
    check({tag, "_x"}, int'(o_x), 0);
    check({tag, "_y"}, int'(o_y), 0);
  endtask

  initial begin
    rst = 1'b1; dval_in = 1'b0; x_in = '0; y_in = '0; d_in = '0; pat_in = '0; mode_in = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    log_q.delete();
    stream_frame(0, 0, 0, 1'b0, 0, LW);
    drain();
    check_first("ramp_rggb", 'h001, 'h005, 'h00A);
    check("ramp_rggb_x", log_q[0].x, 0);
    check("ramp_rggb_y", log_q[0].y, 0);

    log_q.delete();
    stream_frame(0, 3, 0, 1'b0, 0, LW);
    drain();
    check_first("ramp_bggr", 'h00A, 'h005, 'h001);

    log_q.delete();
    stream_frame(0, 3, 1, 1'b0, 0, LW);
    drain();
    check_first("ramp_gray", 'h005, 'h005, 'h005);
    check("ramp_gray_33", log_q[5].r, 'h017);

    log_q.delete();
    stream_frame(1, 0, 0, 1'b0, 0, LW);
    drain();
    check_first("max_colour", 'hFFF, 'hFFF, 'hFFF);

    log_q.delete();
    stream_frame(1, 1, 1, 1'b0, 0, LW);
    drain();
    check_first("max_gray", 'hFFF, 'hFFF, 'hFFF);

    log_q.delete();
    stream_frame(2, 0, 0, 1'b0, 0, LW);
    drain();
    check("green_avg_count", log_q.size(), 12);
    check("green_avg", log_q[0].g, 'h800);

    log_q.delete();
    stream_frame(0, 0, 0, 1'b0, 1, LW);
    drain();
    check_first("ramp_bubbles", 'h001, 'h005, 'h00A);

    log_q.delete();
    stream_frame(0, 0, 0, 1'b0, 0, LW + 2);
    drain();
    check_first("ramp_wide", 'h001, 'h005, 'h00A);

    for (int f = 0; f < 4; f++) begin
      log_q.delete();
      stream_frame(3, 0, 0, 1'b1, 2, LW + 2);
      drain();
      check("rand_count", log_q.size(), 12);
    end

    for (int x = 0; x < LW; x++) drive_pix(x, 0, gen(3, x, 0), 0, 0);
    drive_pix(0, 1, gen(3, 0, 1), 0, 0);
    drive_pix(1, 1, gen(3, 1, 1), 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1; dval_in = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    log_q.delete();
    repeat (6) @(negedge clk);
    check_outputs_zero("post_rst");
    check("post_rst_pulses", log_q.size(), 0);

    log_q.delete();
    stream_frame(3, 0, 0, 1'b1, 2, LW);
    drain();
    check("after_rst_count", log_q.size(), 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bayer_demosaic_2x2.md
# bayer_demosaic_2x2

Parametrised Bayer-to-RGB converter for the camera capture path. Takes the raw sensor pixel stream with its X/Y counters, buffers one line, and forms non-overlapping 2x2 Bayer windows. Each window produces one RGB (or grayscale) output pixel at half resolution in both axes. Successor to the fixed 12-bit RGGB converter: it adds configurable width and line length, runtime Bayer phase, a grayscale mode, and output coordinates.

## Interface
- DATA_W, 12, pixel/colour width
- X_W, 11, width of X/Y counters
- LINE_W, 640, maximum pixels per row (line-buffer depth)
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iX_Cont  in  X_W  column of current input pixel
- iY_Cont  in  X_W  row of current input pixel
- iDATA  in  DATA_W  raw Bayer sample
- iDVAL  in  1  input sample valid
- iPATTERN  in  2  Bayer phase: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR (top-left, top-right, bottom-left, bottom-right)
- iMODE  in  1  0 colour, 1 grayscale
- oRed, oGreen, oBlue  out  DATA_W  output colour
- oX, oY  out  X_W  output coordinates (iX_Cont>>1, iY_Cont>>1 of completing pixel)
- oDVAL  out  1  output valid, one-cycle pulse per window

## Operation
- An input is accepted when iDVAL=1 and iX_Cont < LINE_W. An input with iX_Cont >= LINE_W is dropped: no buffer write, no output.
- Line buffer: LINE_W x DATA_W, synchronous read and write at address iX_Cont. Each accepted pixel reads the value stored from the previous row, then overwrites that entry with iDATA (read-before-write).
- Column registers hold the previous accepted pixel of the current row and of the previous row. They update only on accepted pixels.
- Window completes on an accepted pixel with iX_Cont[0]=1 and iY_Cont[0]=1. The window is P00 (prev row, prev col), P01 (prev row, cur col), P10 (cur row, prev col) and P11 (current pixel).
- Colour assignment follows iPATTERN, sampled with the completing pixel. The two greens are G1 and G2.
- Colour mode:
  - R and B are passed through.
  - G = (G1+G2)>>1, computed in DATA_W+1 bits, truncated.
- Grayscale mode: Y = (P00+P01+P10+P11)>>2, computed in DATA_W+2 bits; oRed=oGreen=oBlue=Y.
- No saturation logic is needed: results never exceed 2^DATA_W-1.
- Outputs hold their last value between oDVAL pulses.
- Line-buffer contents are not cleared by reset. Windows whose previous row was never written in the current frame give undefined colour but correct oDVAL/oX/oY.

## Timing
- Reset values: oRed, oGreen, oBlue, oX, oY = 0; oDVAL = 0; column registers and pipeline valids = 0.
- Latency: a completing pixel sampled at edge N produces outputs and oDVAL=1 after edge N+2. oDVAL drops after edge N+3 unless another window completes.
- Pipeline stages:
  - Stage 1: sample inputs and read the line buffer.
  - Stage 2: align the window and compute.
  - Stage 3: output register.
- iDVAL=0 cycles are bubbles. Windows in flight still drain at fixed latency, and no state other than the pipeline advances.
- Back-to-back completing pixels (every other cycle at full rate) produce oDVAL pulses spaced identically.
- iPATTERN/iMODE changes take effect for windows completing at or after the edge that samples the new value. In-flight windows are unaffected.
- Asserting iRST mid-stream immediately clears oDVAL and all pipeline valids. In-flight windows are discarded. After release, the first output needs a fresh completing pixel.

## Test plan
- Stream an 8x6 ramp, value = 8y+x+1, with LINE_W=8, RGGB, colour mode. Window (1,1) gives R=0x001, G=0x005, B=0x00A, oX=0, oY=0. Exactly 12 oDVAL pulses in total, each 2 cycles after its completing edge.
- Same ramp in BGGR: window (1,1) gives R=0x00A, G=0x005, B=0x001. Then iMODE=1: all three outputs = 0x005; window (3,3) gives all = 0x017.
- All samples 0xFFF in colour and grayscale modes: outputs = 0xFFF, no wrap. Samples G1=0xFFF, G2=0x001: G=0x800.
- Insert iDVAL=0 bubbles between every pixel of the ramp: identical output values and coordinates to the first test, with the same 2-cycle latency from each completing pixel.
- Pixels with iX_Cont=8..9 at LINE_W=8 are ignored: no oDVAL pulses from them, and row data at x<8 is unaffected.
- Assert iRST at the edge after a completing pixel: no oDVAL pulse for that window. All outputs are 0 until the next completing pixel plus 2 cycles.
